mem_port_arbiter: RTL

- Shares the single memory port between the instruction-fetch requester and the data (load/store) requester.
- Accepts one transaction at a time: latches it, drives it onto the memory port, waits for the response and routes it back to the owner.
- Data requests win by default, with a starvation limit that guarantees fetch progress.
- Consumes the writeback-stage flush (exception or ertn) to discard the response of a fetch that is already in flight.

---
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between the instruction-fetch requester and the
//   load/store requester. One transaction is held at a time: it is granted in
//   IDLE, latched, presented on mem_* until accepted, and its response is
//   routed back to whichever requester owns it.
//
//   Data wins arbitration by default. After STARVE_LIMIT consecutive data
//   grants with a fetch waiting, the fetch is forced to win the next grant.
//   A writeback flush cancels the response of an in-flight fetch. The memory
//   side still completes that fetch, but the response is dropped.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   flush                       pipeline flush from writeback
//   inst_req/inst_addr          fetch request in
//   inst_addr_ok                fetch accepted this cycle
//   inst_data_ok/inst_rdata     fetch response
//   data_req/wr/wstrb/addr/wdata  load/store request in
//   data_addr_ok                load/store accepted this cycle
//   data_data_ok/data_rdata     load data / store completion
//   mem_req/wr/wstrb/addr/wdata memory request out
//   mem_addr_ok                 memory accepted the request
//   mem_data_ok/mem_rdata       memory response
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transaction held; grants are decided combinationally
// REQ   | mem_req raised with the latched fields, waiting for mem_addr_ok
// WAIT  | memory accepted the request, waiting for mem_data_ok

module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state;
    state_t      state_nxt;

    logic        owner_data;
    logic        cancel;
    logic [3:0]  starve_cnt;
    logic        wr_q;
    logic [3:0]  wstrb_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        force_inst;
    logic        data_grant;
    logic        inst_grant;

    assign force_inst = inst_req && (starve_cnt == LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        data_grant   = 1'b0;
        inst_grant   = 1'b0;
        mem_req      = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        case (state)
            IDLE: begin
                data_grant = data_req && !force_inst;
                inst_grant = inst_req && !flush && (!data_req || force_inst);
                if (data_grant || inst_grant) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // Held until accepted, even under flush: the memory side
                // cannot take a request back.
                mem_req = 1'b1;
                if (mem_addr_ok) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_data_ok) begin
                    state_nxt    = IDLE;
                    data_data_ok = owner_data;
                    // A flush arriving with the final beat also kills it.
                    inst_data_ok = !owner_data && !cancel && !flush;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign inst_addr_ok = inst_grant;
    assign data_addr_ok = data_grant;

    // Latched request fields; an inst grant carries no write data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_data <= 1'b0;
            wr_q       <= 1'b0;
            wstrb_q    <= 4'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
        end else if (data_grant) begin
            owner_data <= 1'b1;
            wr_q       <= data_wr;
            wstrb_q    <= data_wstrb;
            addr_q     <= data_addr;
            wdata_q    <= data_wdata;
        end else if (inst_grant) begin
            owner_data <= 1'b0;
            wr_q       <= 1'b0;
            wstrb_q    <= 4'd0;
            addr_q     <= inst_addr;
            wdata_q    <= 32'd0;
        end
    end

    // Completion clears cancel ahead of a same-cycle flush so the next fetch
    // starts clean; the suppression of that final beat is done in the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cancel <= 1'b0;
        end else if (state == WAIT && mem_data_ok) begin
            cancel <= 1'b0;
        end else if (flush && !owner_data && (state == REQ || state == WAIT)) begin
            cancel <= 1'b1;
        end
    end

    // Counts data grants that bypassed a waiting fetch; only IDLE cycles
    // matter since grants are only made there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (state == IDLE) begin
            if (inst_grant || !inst_req) begin
                starve_cnt <= 4'd0;
            end else if (data_grant && starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    assign mem_wr     = wr_q;
    assign mem_wstrb  = wstrb_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule
